// File: rtl/lab2c_pkg.sv
// Shared types and constants for the decimal-entry block feeding the 9-bit adder path.
package lab2c_pkg;

    typedef enum logic [1:0] {
        StEntry  = 2'd0,
        StScale  = 2'd1,
        StAdd    = 2'd2,
        StCommit = 2'd3
    } state_t;

    localparam int unsigned SUM_W   = 9;
    localparam int unsigned ACC_W   = 10;
    localparam int unsigned SAT_MAX = 511;
    localparam int unsigned BCD_MAX = 9;

    function automatic logic [SUM_W-1:0] sat_sum(input logic [ACC_W-1:0] acc);
        return (acc > ACC_W'(SAT_MAX)) ? SUM_W'(SAT_MAX) : acc[SUM_W-1:0];
    endfunction

endpackage

// File: rtl/bcd_entry_converter_if.sv
// Digit-entry handshake and committed-result bundle for bcd_entry_converter.
interface bcd_entry_converter_if;
    import lab2c_pkg::*;

    logic             digit_valid;
    logic [3:0]       digit;
    logic             digit_ready;
    logic             enter;
    logic             clear;
    logic             value_valid;
    logic [SUM_W-1:0] value;
    logic             overflow;
    logic             err_digit;
    logic [1:0]       digit_count;

    modport master (
        output digit_valid, digit, enter, clear,
        input  digit_ready, value_valid, value, overflow, err_digit, digit_count
    );

    modport slave (
        input  digit_valid, digit, enter, clear,
        output digit_ready, value_valid, value, overflow, err_digit, digit_count
    );

endinterface

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit as (acc<<3) + (acc<<1) + digit; inverse of the digit extractor.
module bcd_mac10
    import lab2c_pkg::*;
(
    input  logic [ACC_W-1:0] i_acc,
    input  logic [ACC_W-1:0] i_scaled,
    input  logic [3:0]       i_digit,
    output logic [ACC_W-1:0] o_times8,
    output logic [ACC_W-1:0] o_sum
);

    // Upper bits drop safely: scaling only happens while acc <= 99.
    assign o_times8 = {i_acc[ACC_W-4:0], 3'b000};
    assign o_sum    = i_scaled + {i_acc[ACC_W-2:0], 1'b0} + ACC_W'(i_digit);

endmodule

// File: rtl/bcd_entry_converter.sv
// Accumulates up to MAX_DIGITS BCD digits (MSD first) and commits a saturated 9-bit binary value.
module bcd_entry_converter
    import lab2c_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    bcd_entry_converter_if.slave bus
);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_tmp;
    logic [3:0]       r_dig;
    logic [1:0]       r_count;
    logic             r_enter_pend;
    logic [SUM_W-1:0] r_value;
    logic             r_overflow;
    logic             r_value_valid;
    logic             r_err_digit;

    logic             w_digit_ready;
    logic             w_accept;
    logic             w_digit_ok;
    logic             w_enter_any;
    logic [ACC_W-1:0] w_times8;
    logic [ACC_W-1:0] w_sum;

    assign w_digit_ready = (r_state == StEntry) && (r_count < 2'(MAX_DIGITS));
    assign w_accept      = bus.digit_valid && w_digit_ready;
    assign w_digit_ok    = (bus.digit <= 4'(BCD_MAX));
    assign w_enter_any   = bus.enter || r_enter_pend;

    bcd_mac10 u_mac (
        .i_acc    (r_acc),
        .i_scaled (r_tmp),
        .i_digit  (r_dig),
        .o_times8 (w_times8),
        .o_sum    (w_sum)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StEntry;
            r_acc         <= '0;
            r_tmp         <= '0;
            r_dig         <= '0;
            r_count       <= '0;
            r_enter_pend  <= 1'b0;
            r_value       <= '0;
            r_overflow    <= 1'b0;
            r_value_valid <= 1'b0;
            r_err_digit   <= 1'b0;
        end else if (bus.clear) begin
            // Abort without touching the last committed value/overflow.
            r_state       <= StEntry;
            r_acc         <= '0;
            r_tmp         <= '0;
            r_count       <= '0;
            r_enter_pend  <= 1'b0;
            r_value_valid <= 1'b0;
            r_err_digit   <= 1'b0;
        end else begin
            r_value_valid <= 1'b0;
            r_err_digit   <= 1'b0;
            if (bus.enter) begin
                r_enter_pend <= 1'b1;
            end
            unique case (r_state)
                StEntry: begin
                    if (w_accept) begin
                        if (w_digit_ok) begin
                            r_dig   <= bus.digit;
                            r_state <= StScale;
                        end else begin
                            r_err_digit <= 1'b1;
                        end
                    end else if (w_enter_any) begin
                        r_state <= StCommit;
                    end
                end
                StScale: begin
                    r_tmp   <= w_times8;
                    r_state <= StAdd;
                end
                StAdd: begin
                    r_acc   <= w_sum;
                    r_count <= r_count + 2'd1;
                    r_state <= w_enter_any ? StCommit : StEntry;
                end
                StCommit: begin
                    r_value       <= sat_sum(r_acc);
                    r_overflow    <= (r_acc > ACC_W'(SAT_MAX));
                    r_value_valid <= 1'b1;
                    r_acc         <= '0;
                    r_count       <= '0;
                    r_enter_pend  <= 1'b0;
                    r_state       <= StEntry;
                end
                default: r_state <= StEntry;
            endcase
        end
    end

    assign bus.digit_ready = w_digit_ready;
    assign bus.value_valid = r_value_valid;
    assign bus.value       = r_value;
    assign bus.overflow    = r_overflow;
    assign bus.err_digit   = r_err_digit;
    assign bus.digit_count = r_count;

endmodule

// File: tb/tb_bcd_entry_converter.sv
// Table-driven and directed checks for bcd_entry_converter.
module tb_bcd_entry_converter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    bcd_entry_converter_if bus ();

    bcd_entry_converter #(
        .MAX_DIGITS (3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned nd;
        logic [3:0]  d0;
        logic [3:0]  d1;
        logic [3:0]  d2;
        logic [8:0]  exp_val;
        logic        exp_ovf;
        string       name;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic send_digit(input logic [3:0] d, input string name);
        int n;
        n = 0;
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        while (!bus.digit_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " digit accepted in time"}, 32'(n < 20), 32'd1);
        @(negedge clk);
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
    endtask

    task automatic wait_vv(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.value_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_vv_checked(input string name, input logic [8:0] ev, input logic eo);
        bit seen;
        wait_vv(seen);
        check({name, " value_valid seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, " value"}, 32'(bus.value), 32'(ev));
            check({name, " overflow"}, 32'(bus.overflow), 32'(eo));
            check({name, " digit_count"}, 32'(bus.digit_count), 32'd0);
            @(negedge clk);
            check({name, " value_valid one cycle"}, 32'(bus.value_valid), 32'd0);
            check({name, " value held"}, 32'(bus.value), 32'(ev));
        end
    endtask

    task automatic enter_and_check(input string name, input logic [8:0] ev, input logic eo);
        bus.enter = 1'b1;
        @(negedge clk);
        bus.enter = 1'b0;
        wait_vv_checked(name, ev, eo);
    endtask

    initial begin
        bit seen;
        logic [3:0] ds [3];
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.enter       = 1'b0;
        bus.clear       = 1'b0;

        vecs[0] = '{3, 4'd2, 4'd5, 4'd5, 9'd255, 1'b0, "d255"};
        vecs[1] = '{3, 4'd9, 4'd9, 4'd9, 9'd511, 1'b1, "d999 sat"};
        vecs[2] = '{1, 4'd7, 4'd0, 4'd0, 9'd7,   1'b0, "d7 after sat"};
        vecs[3] = '{0, 4'd0, 4'd0, 4'd0, 9'd0,   1'b0, "empty entry"};
        vecs[4] = '{3, 4'd5, 4'd1, 4'd1, 9'd511, 1'b0, "d511 edge"};
        vecs[5] = '{3, 4'd5, 4'd1, 4'd2, 9'd511, 1'b1, "d512 sat"};
        vecs[6] = '{3, 4'd0, 4'd0, 4'd9, 9'd9,   1'b0, "d009"};
        vecs[7] = '{2, 4'd1, 4'd0, 4'd0, 9'd10,  1'b0, "d10"};
        vecs[8] = '{3, 4'd3, 4'd0, 4'd8, 9'd308, 1'b0, "d308"};

        repeat (3) @(negedge clk);
        check("reset value", 32'(bus.value), 32'd0);
        check("reset overflow", 32'(bus.overflow), 32'd0);
        check("reset value_valid", 32'(bus.value_valid), 32'd0);
        check("reset err_digit", 32'(bus.err_digit), 32'd0);
        check("reset digit_count", 32'(bus.digit_count), 32'd0);
        check("reset digit_ready", 32'(bus.digit_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            ds[0] = vecs[v].d0;
            ds[1] = vecs[v].d1;
            ds[2] = vecs[v].d2;
            for (int k = 0; k < int'(vecs[v].nd); k++) begin
                send_digit(ds[k], vecs[v].name);
            end
            enter_and_check(vecs[v].name, vecs[v].exp_val, vecs[v].exp_ovf);
            repeat (2) @(negedge clk);
        end

        // Illegal digit: flagged for one cycle, not counted.
        send_digit(4'd12, "bad digit");
        check("err_digit pulse", 32'(bus.err_digit), 32'd1);
        check("err count unchanged", 32'(bus.digit_count), 32'd0);
        @(negedge clk);
        check("err_digit one cycle", 32'(bus.err_digit), 32'd0);
        check("err ready again", 32'(bus.digit_ready), 32'd1);
        send_digit(4'd4, "after err");
        enter_and_check("after err d4", 9'd4, 1'b0);

        // Fourth digit must stall, never be taken.
        send_digit(4'd1, "stall");
        send_digit(4'd2, "stall");
        send_digit(4'd3, "stall");
        bus.digit_valid = 1'b1;
        bus.digit       = 4'd4;
        repeat (10) @(negedge clk);
        check("stall ready low", 32'(bus.digit_ready), 32'd0);
        check("stall count 3", 32'(bus.digit_count), 32'd3);
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        enter_and_check("stall d123", 9'd123, 1'b0);

        // Reset mid-entry.
        send_digit(4'd4, "rst mid");
        send_digit(4'd2, "rst mid");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst value", 32'(bus.value), 32'd0);
        check("rst overflow", 32'(bus.overflow), 32'd0);
        check("rst count", 32'(bus.digit_count), 32'd0);
        check("rst ready", 32'(bus.digit_ready), 32'd1);
        check("rst value_valid", 32'(bus.value_valid), 32'd0);
        send_digit(4'd8, "after rst");
        enter_and_check("after rst d8", 9'd8, 1'b0);

        // Digit and enter in the same cycle: digit is taken first.
        bus.digit_valid = 1'b1;
        bus.digit       = 4'd6;
        bus.enter       = 1'b1;
        check("same-cycle ready", 32'(bus.digit_ready), 32'd1);
        @(negedge clk);
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.enter       = 1'b0;
        check("same-cycle no early commit", 32'(bus.value_valid), 32'd0);
        wait_vv_checked("same-cycle d6", 9'd6, 1'b0);

        // Clear while in SCALE: no commit, last value kept, accumulator zeroed.
        send_digit(4'd7, "clear");
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        wait_vv(seen);
        check("clear no value_valid", 32'(seen), 32'd0);
        check("clear value kept", 32'(bus.value), 32'd6);
        check("clear count zero", 32'(bus.digit_count), 32'd0);
        enter_and_check("after clear acc0", 9'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
